// File: rtl/counter_timer_scheduler.sv
// Round-robin scheduler that time-shares one 32-bit up/down counter between
// NUM_REQ one-shot delay requesters: load twice, settle, run to wrap, pulse done.
module counter_timer_scheduler #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  period_flat,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   ctr_load,
    output logic                   ctr_up_down,
    output logic [31:0]            ctr_load_value,
    input  logic [31:0]            ctr_count,
    input  logic                   ctr_interrupt
);
    localparam int              IW   = $clog2(NUM_REQ);
    localparam logic [IW:0]     NR   = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0]   LAST = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, SETTLE, RUN, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  owner;
    logic [IW-1:0]  pick;
    logic           found;
    logic [IW:0]    cand;
    logic [31:0]    period [NUM_REQ];
    logic [31:0]    pick_value;
    logic           load_mismatch_unused;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            period[i] = period_flat[32*i +: 32];
        end
    end

    // Scan from the top down so the lowest offset from rr_ptr is assigned last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand >= NR) cand = cand - NR;
            if (req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    // Start value is 0xFFFFFFFF - P; P = all-ones is clamped so the run still ends.
    assign pick_value = (period[pick] == 32'hFFFF_FFFF) ? 32'h0000_0001 : ~period[pick];

    assign busy = (state != IDLE);

    // Debug observation of the counter: after the two load cycles count must hold the start value.
    assign load_mismatch_unused = (state == SETTLE) && (ctr_count != ctr_load_value);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= '0;
            done           <= '0;
            ctr_load       <= 1'b0;
            ctr_up_down    <= 1'b0;
            ctr_load_value <= '0;
            rr_ptr         <= '0;
            owner          <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    ctr_load    <= 1'b0;
                    ctr_up_down <= 1'b0;
                    grant       <= '0;
                    if (found) begin
                        grant          <= NUM_REQ'(1) << pick;
                        owner          <= pick;
                        ctr_load_value <= pick_value;
                        ctr_load       <= 1'b1;
                        rr_ptr         <= (pick == LAST) ? '0 : pick + 1'b1;
                        state          <= LOAD1;
                    end
                end
                LOAD1: state <= LOAD2;
                LOAD2: begin
                    ctr_load    <= 1'b0;
                    ctr_up_down <= 1'b1;
                    state       <= SETTLE;
                end
                // Interrupt here still reflects the pre-load count, so it is not looked at.
                SETTLE: state <= RUN;
                RUN: begin
                    if (ctr_interrupt) begin
                        done  <= grant;
                        state <= DONE;
                    end else if (!req[owner]) begin
                        grant       <= '0;
                        ctr_up_down <= 1'b0;
                        state       <= IDLE;
                    end
                end
                DONE: begin
                    grant       <= '0;
                    ctr_up_down <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_timer_scheduler.sv
// Bench for counter_timer_scheduler: behavioural two-stage counter, directed
// vector table, hand sequences for reset/clamp, and random traffic vs. a model.
module tb_counter_timer_scheduler;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0;
    logic [32*N-1:0]   period_flat = '0;
    logic [N-1:0]      grant, done;
    logic              busy, ctr_load, ctr_up_down;
    logic [31:0]       ctr_load_value;
    logic [31:0]       ctr_count;
    logic              ctr_interrupt;

    int checks = 0;
    int errors = 0;
    int rr_model = 0;
    logic force_int = 1'b0;

    // Behavioural counter: load captures load_reg, a second load copies it to count.
    logic [31:0] cnt = '0, load_reg = '0;
    logic        load_d = 1'b0, cnt_int = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        load_d  <= ctr_load;
        cnt_int <= (cnt == 32'hFFFF_FFFF);
        if (ctr_load) begin
            load_reg <= ctr_load_value;
            if (load_d) cnt <= load_reg;
        end else begin
            cnt <= ctr_up_down ? cnt + 32'd1 : cnt - 32'd1;
        end
    end

    assign ctr_count     = cnt;
    assign ctr_interrupt = cnt_int | force_int;

    counter_timer_scheduler #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .period_flat(period_flat),
        .grant(grant), .done(done), .busy(busy), .ctr_load(ctr_load),
        .ctr_up_down(ctr_up_down), .ctr_load_value(ctr_load_value),
        .ctr_count(ctr_count), .ctr_interrupt(ctr_interrupt)
    );

    typedef struct {
        logic [N-1:0] mask;
        logic [31:0]  p;
        logic [31:0]  exp_val;
        int           exp_lat;
        int           withdraw;
        bit           stale;
    } vec_t;

    vec_t tbl [8];
    int   rr_order [5];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
        int w = -1;
        for (int i = 0; i < N; i++) begin
            if (w < 0 && mask[(ptr + i) % N]) w = (ptr + i) % N;
        end
        return w;
    endfunction

    function automatic logic [31:0] eff_p(input logic [31:0] p);
        return (p == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : p;
    endfunction

    task automatic set_all_periods(input logic [31:0] p);
        for (int i = 0; i < N; i++) period_flat[32*i +: 32] = p;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        force_int = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rr_model = 0;
    endtask

    // One transaction from the IDLE cycle: returns load value and LOAD1-to-done latency (-1 on abort).
    task automatic txn(input logic [N-1:0] mask, input int exp_w, input int withdraw, input bit stale,
                       output logic [31:0] got_val, output int got_lat);
        int waits = 0, lat = 0, loads = 0;
        bit got_done = 0, aborted = 0;
        logic [1:0] wi;
        got_val = '0;
        got_lat = -2;
        wi = exp_w[1:0];
        req = mask;
        do begin
            @(negedge clk);
            waits++;
        end while (grant == '0 && waits < 10);
        chk("grant_wait", waits, 1);
        chk("grant_onehot", grant, N'(1) << exp_w);
        if (grant == '0) return;
        got_val = ctr_load_value;
        rr_model = (exp_w + 1) % N;
        while (lat < 1200) begin
            if (ctr_load) loads++;
            if (lat == 2) chk("settle_ctrl", {ctr_load, ctr_up_down}, 2'b01);
            force_int = stale && (lat == 2);
            if (withdraw >= 0 && lat == 3 + withdraw) req[wi] = 1'b0;
            if (done != '0) begin
                chk("done_bit", done, grant);
                got_done = 1;
                break;
            end
            if (grant == '0) begin
                aborted = 1;
                chk("abort_idle", {busy, done}, '0);
                break;
            end
            @(negedge clk);
            lat++;
        end
        force_int = 1'b0;
        if (!got_done && !aborted) chk("txn_timeout", 1, 0);
        chk("load_cycles", loads, 2);
        if (got_done) begin
            @(negedge clk);
            chk("post_done_idle", {busy, grant, done}, '0);
            got_lat = lat;
        end else if (aborted) begin
            got_lat = -1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] gv, pw;
        int gl, w, wd, el;
        bit st;
        logic [N-1:0] m;

        tbl[0] = '{4'b0001, 32'd10,  32'hFFFF_FFF5, 14, -1, 0};
        tbl[1] = '{4'b0100, 32'd0,   32'hFFFF_FFFF,  4, -1, 0};
        tbl[2] = '{4'b0100, 32'd5,   32'hFFFF_FFFA,  9, -1, 1};
        tbl[3] = '{4'b0001, 32'd2,   32'hFFFF_FFFD,  6, -1, 0};
        tbl[4] = '{4'b1010, 32'd100, 32'hFFFF_FF9B, -1, 20, 0};
        tbl[5] = '{4'b1000, 32'd7,   32'hFFFF_FFF8, 11, -1, 0};
        tbl[6] = '{4'b0001, 32'd1,   32'hFFFF_FFFE, -1,  0, 0};
        tbl[7] = '{4'b0100, 32'd3,   32'hFFFF_FFFC,  7,  3, 0};
        rr_order = '{0, 1, 2, 3, 0};

        // Reset state
        @(negedge clk);
        chk("reset_state", {grant, done, busy, ctr_load, ctr_up_down, ctr_load_value}, '0);
        do_reset();

        // Directed table
        for (int k = 0; k < 8; k++) begin
            set_all_periods(tbl[k].p);
            w = model_pick(tbl[k].mask, rr_model);
            txn(tbl[k].mask, w, tbl[k].withdraw, tbl[k].stale, gv, gl);
            chk($sformatf("tbl%0d_value", k), gv, tbl[k].exp_val);
            chk($sformatf("tbl%0d_latency", k), gl, tbl[k].exp_lat);
        end

        // Round-robin with all requesters held
        do_reset();
        set_all_periods(32'd3);
        for (int k = 0; k < 5; k++) begin
            w = model_pick(4'b1111, rr_model);
            chk($sformatf("rr%0d_order", k), w, rr_order[k]);
            txn(4'b1111, rr_order[k], -1, 0, gv, gl);
            chk($sformatf("rr%0d_latency", k), gl, 7);
        end

        // Reset during RUN, then a fresh short request
        do_reset();
        set_all_periods(32'd50);
        req = 4'b0001;
        for (int k = 0; k < 10 && grant == '0; k++) @(negedge clk);
        chk("rst_run_granted", grant, 4'b0001);
        repeat (12) @(negedge clk);
        chk("rst_run_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_run_outputs", {grant, done, busy, ctr_load, ctr_up_down, ctr_load_value}, '0);
        reset = 1'b0;
        rr_model = 0;
        set_all_periods(32'd5);
        txn(4'b0001, 0, -1, 0, gv, gl);
        chk("after_rst_value", gv, 32'hFFFF_FFFA);
        chk("after_rst_latency", gl, 9);

        // Clamp of P = all-ones; truncated run
        do_reset();
        set_all_periods(32'hFFFF_FFFF);
        req = 4'b0001;
        for (int k = 0; k < 10 && grant == '0; k++) @(negedge clk);
        chk("clamp_value", ctr_load_value, 32'h0000_0001);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            chk("clamp_run", {busy, done}, {1'b1, 4'b0000});
        end
        do_reset();

        // Random traffic vs. model
        for (int k = 0; k < 40; k++) begin
            m = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) period_flat[32*i +: 32] = $urandom_range(0, 12);
            wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            st = 1'($urandom_range(0, 1));
            w  = model_pick(m, rr_model);
            pw = eff_p(period_flat[32*w +: 32]);
            el = (wd >= 0 && wd < int'(pw)) ? -1 : int'(pw) + 4;
            txn(m, w, wd, st, gv, gl);
            chk("rand_value", gv, 32'hFFFF_FFFF - pw);
            chk("rand_latency", gl, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
